// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Multi-channel ADC capture controller. It decimates and
//               triggers on a sample stream, fills a per-channel capture
//               buffer, and exposes control, status and readback through an
//               Avalon-MM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic                main_clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [NCH*DW-1:0]   adc_data,
    input  logic [4:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    output logic [2*NCH-1:0]    gain_sel,
    output logic                capture_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic                 first_q, first_d;
    logic [DW-1:0]        prev_q, prev_d;
    logic [15:0]          decim_cnt_q, decim_cnt_d;
    logic                 trig_en_q, trig_en_d;
    logic                 trig_fall_q, trig_fall_d;
    logic [DW-1:0]        trig_level_q, trig_level_d;
    logic [7:0]           trig_ch_q, trig_ch_d;
    logic [15:0]          decim_q, decim_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [7:0]           rd_ch_q, rd_ch_d;
    logic [NCH*DW-1:0]    live_q, live_d;
    logic [2*NCH-1:0]     gain_q, gain_d;
    logic [2*NCH-1:0]     gain_sel_q, gain_sel_d;
    logic [15:0]          readdata_q, readdata_d;

    logic                 w_arm;
    logic                 w_abort;
    logic                 w_arm_go;
    logic                 w_accepted;
    logic [15:0]          w_decim_limit;
    logic [DW-1:0]        w_trig_sample;
    logic                 w_trig_hit;
    logic                 w_buf_we;
    logic [AW-1:0]        w_buf_idx;
    logic [DW-1:0]        w_rd_sample;

    logic [DW-1:0]        buf_mem [NCH][DEPTH];

    assign w_arm         = write && (address == 5'd0) && writedata[0];
    assign w_abort       = write && (address == 5'd0) && writedata[1];
    // Arm only takes effect from IDLE/DONE and never together with abort
    assign w_arm_go      = w_arm && !w_abort &&
                           ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_accepted    = sample_valid && (decim_cnt_q == 16'd0);
    assign w_decim_limit = (decim_q <= 16'd1) ? 16'd0 : (decim_q - 16'd1);

    // Select the trigger channel sample; out-of-range channel falls back to 0
    always_comb begin
        w_trig_sample = adc_data[DW-1:0];
        for (int k = 0; k < NCH; k++) begin
            if (trig_ch_q == 8'(k)) begin
                w_trig_sample = adc_data[k*DW +: DW];
            end
        end
        if (trig_fall_q) begin
            w_trig_hit = (prev_q >= trig_level_q) && (trig_level_q > w_trig_sample);
        end else begin
            w_trig_hit = (prev_q < trig_level_q) && (trig_level_q <= w_trig_sample);
        end
    end

    // Capture FSM: next state, write pointer, trigger history, buffer write
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        first_d   = first_q;
        prev_d    = prev_q;
        w_buf_we  = 1'b0;
        w_buf_idx = wr_ptr_q;
        if (w_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_arm) begin
                        state_d  = ST_ARMED;
                        wr_ptr_d = '0;
                        first_d  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_accepted) begin
                        if (!trig_en_q) begin
                            w_buf_we  = 1'b1;
                            w_buf_idx = '0;
                            wr_ptr_d  = AW'(1);
                            state_d   = ST_CAPTURE;
                        end else begin
                            prev_d  = w_trig_sample;
                            first_d = 1'b0;
                            if (!first_q && w_trig_hit) begin
                                w_buf_we  = 1'b1;
                                w_buf_idx = '0;
                                wr_ptr_d  = AW'(1);
                                state_d   = ST_CAPTURE;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_accepted) begin
                        w_buf_we  = 1'b1;
                        w_buf_idx = wr_ptr_q;
                        if (wr_ptr_q == AW'(DEPTH-1)) begin
                            state_d = ST_DONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + AW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register file writes, readback pointer, decimation, live and gain values
    always_comb begin
        trig_en_d    = trig_en_q;
        trig_fall_d  = trig_fall_q;
        trig_level_d = trig_level_q;
        trig_ch_d    = trig_ch_q;
        decim_d      = decim_q;
        rd_ptr_d     = rd_ptr_q;
        rd_ch_d      = rd_ch_q;
        gain_d       = gain_q;
        live_d       = live_q;
        decim_cnt_d  = decim_cnt_q;
        if (write) begin
            case (address)
                5'd0: begin
                    trig_en_d   = writedata[2];
                    trig_fall_d = writedata[3];
                end
                5'd2: trig_level_d = writedata[DW-1:0];
                5'd3: trig_ch_d    = writedata[7:0];
                5'd4: decim_d      = writedata;
                5'd5: rd_ptr_d     = writedata[AW-1:0];
                5'd7: rd_ch_d      = writedata[7:0];
                default: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (address == 5'(16 + k)) begin
                            gain_d[2*k +: 2] = writedata[1:0];
                        end
                    end
                end
            endcase
        end
        if (read && (address == 5'd6)) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (sample_valid) begin
            live_d      = adc_data;
            decim_cnt_d = (decim_cnt_q >= w_decim_limit) ? 16'd0 : (decim_cnt_q + 16'd1);
        end
        if (w_arm_go) begin
            decim_cnt_d = 16'd0;
        end
        for (int k = 0; k < NCH; k++) begin
            gain_sel_d[2*k +: 2] = (gain_q[2*k +: 2] == 2'd3) ? 2'd1 : gain_q[2*k +: 2];
        end
    end

    // Buffer readback source for RD_DATA; channels beyond NCH read as zero
    always_comb begin
        w_rd_sample = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_ch_q == 8'(k)) begin
                w_rd_sample = buf_mem[k][rd_ptr_q];
            end
        end
    end

    // Registered read mux; idle cycles return zero
    always_comb begin
        readdata_d = 16'd0;
        if (read) begin
            case (address)
                5'd0: readdata_d[3:2]      = {trig_fall_q, trig_en_q};
                5'd1: readdata_d[2:0]      = {(state_q == ST_DONE), state_q};
                5'd2: readdata_d[DW-1:0]   = trig_level_q;
                5'd3: readdata_d[7:0]      = trig_ch_q;
                5'd4: readdata_d           = decim_q;
                5'd5: readdata_d[AW-1:0]   = rd_ptr_q;
                5'd6: readdata_d[DW-1:0]   = w_rd_sample;
                5'd7: readdata_d[7:0]      = rd_ch_q;
                default: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (address == 5'(8 + k)) begin
                            readdata_d[DW-1:0] = live_q[k*DW +: DW];
                        end
                        if (address == 5'(16 + k)) begin
                            readdata_d[1:0] = gain_q[2*k +: 2];
                        end
                    end
                end
            endcase
        end
    end

    // State and register file flops with asynchronous active-low reset
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            first_q      <= 1'b0;
            prev_q       <= '0;
            decim_cnt_q  <= '0;
            trig_en_q    <= 1'b0;
            trig_fall_q  <= 1'b0;
            trig_level_q <= '0;
            trig_ch_q    <= '0;
            decim_q      <= '0;
            rd_ptr_q     <= '0;
            rd_ch_q      <= '0;
            live_q       <= '0;
            gain_q       <= {NCH{2'b01}};
            gain_sel_q   <= {NCH{2'b01}};
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            first_q      <= first_d;
            prev_q       <= prev_d;
            decim_cnt_q  <= decim_cnt_d;
            trig_en_q    <= trig_en_d;
            trig_fall_q  <= trig_fall_d;
            trig_level_q <= trig_level_d;
            trig_ch_q    <= trig_ch_d;
            decim_q      <= decim_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_ch_q      <= rd_ch_d;
            live_q       <= live_d;
            gain_q       <= gain_d;
            gain_sel_q   <= gain_sel_d;
            readdata_q   <= readdata_d;
        end
    end

    // Capture buffer storage; contents deliberately survive reset and abort
    always_ff @(posedge main_clk) begin
        if (w_buf_we) begin
            for (int k = 0; k < NCH; k++) begin
                buf_mem[k][w_buf_idx] <= adc_data[k*DW +: DW];
            end
        end
    end

    assign readdata     = readdata_q;
    assign gain_sel     = gain_sel_q;
    assign capture_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_ctrl
// Description : Self-checking bench for adc_capture_ctrl: register table,
//               directed capture/trigger/abort/reset sequences and randomized
//               captures against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NSMP  = 120;

    logic        main_clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic [4:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic [3:0]  gain_sel;
    logic        capture_done;

    int total = 0;
    int bad   = 0;

    adc_capture_ctrl #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .main_clk     (main_clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .gain_sel     (gain_sel),
        .capture_done (capture_done)
    );

    always #5 main_clk = ~main_clk;

    typedef struct {
        logic [4:0]  waddr;
        logic [15:0] wdata;
        logic [4:0]  raddr;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge main_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        address = a; writedata = d; write = 1'b1;
        tick(1);
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [15:0] d);
        address = a; read = 1'b1;
        tick(1);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic smp(input logic [7:0] d0, input logic [7:0] d1);
        adc_data = {d1, d0}; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
        logic [15:0] d;
        rd(a, d);
        chk(name, {16'd0, d}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] d;
        int s0 [NSMP];
        int s1 [NSMP];
        int a0 [$];
        int a1 [$];

        tbl[0]  = '{5'd2,  16'h01AB, 5'd2,  16'h00AB};
        tbl[1]  = '{5'd3,  16'h0005, 5'd3,  16'h0005};
        tbl[2]  = '{5'd4,  16'hBEEF, 5'd4,  16'hBEEF};
        tbl[3]  = '{5'd5,  16'h0023, 5'd5,  16'h0003};
        tbl[4]  = '{5'd7,  16'h0001, 5'd7,  16'h0001};
        tbl[5]  = '{5'd0,  16'h000C, 5'd0,  16'h000C};
        tbl[6]  = '{5'd16, 16'h0007, 5'd16, 16'h0003};
        tbl[7]  = '{5'd17, 16'h0002, 5'd17, 16'h0002};
        tbl[8]  = '{5'd24, 16'h0005, 5'd24, 16'h0000};
        tbl[9]  = '{5'd1,  16'hFFFF, 5'd1,  16'h0000};
        tbl[10] = '{5'd8,  16'h0055, 5'd8,  16'h0000};
        tbl[11] = '{5'd0,  16'h0000, 5'd0,  16'h0000};

        // ---- reset state
        #12;
        chk("rst_done", {31'd0, capture_done}, 32'd0);
        chk("rst_gain", {28'd0, gain_sel}, 32'h5);
        chk("rst_rdata", {16'd0, readdata}, 32'd0);
        #3 rst = 1'b1;
        tick(1);
        rd_chk("rst_status", 5'd1, 16'd0);

        // ---- register table
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd_chk($sformatf("reg%0d", i), tbl[i].raddr, tbl[i].exp);
        end
        chk("gain_sel_map", {28'd0, gain_sel}, 32'h9);
        wr(5'd2, 0); wr(5'd3, 0); wr(5'd4, 0); wr(5'd5, 0); wr(5'd7, 0);
        wr(5'd16, 1); wr(5'd17, 1);

        // ---- ramp capture, no trigger, no decimation
        wr(5'd0, 16'h0001);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("ramp_not_done", {31'd0, capture_done}, 32'd0);
            smp(8'(i), 8'(8'hA0 ^ i));
        end
        chk("ramp_done", {31'd0, capture_done}, 32'd1);
        rd_chk("ramp_status", 5'd1, 16'd7);
        for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("ramp_ch0_%0d", i), 5'd6, 16'(i));
        rd_chk("ramp_ptr_wrap", 5'd5, 16'd0);
        wr(5'd7, 1);
        for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("ramp_ch1_%0d", i), 5'd6, 16'(8'hA0 ^ i));
        wr(5'd7, 2);
        rd_chk("rdch_oob", 5'd6, 16'd0);
        rd_chk("rdch_oob_inc", 5'd5, 16'd1);
        wr(5'd7, 0);

        // ---- rising trigger
        wr(5'd2, 16'h0080);
        smp(8'h10, 8'h00);
        wr(5'd0, 16'h0005);
        smp(8'h90, 8'h01);
        rd_chk("rise_first_no_trig", 5'd1, 16'd1);
        smp(8'h70, 8'h02);
        rd_chk("rise_below", 5'd1, 16'd1);
        smp(8'h80, 8'h03);
        rd_chk("rise_trig", 5'd1, 16'd2);
        wr(5'd0, 16'h0002);
        wr(5'd5, 0);
        rd_chk("rise_idx0", 5'd6, 16'h0080);

        // ---- falling trigger
        wr(5'd0, 16'h000D);
        smp(8'h90, 8'h00);
        rd_chk("fall_first_no_trig", 5'd1, 16'd1);
        smp(8'h70, 8'h00);
        rd_chk("fall_trig", 5'd1, 16'd2);
        wr(5'd0, 16'h0002);
        wr(5'd5, 0);
        rd_chk("fall_idx0", 5'd6, 16'h0070);

        // ---- decimation by 3
        wr(5'd4, 3);
        wr(5'd0, 16'h0001);
        for (int v = 0; v < 3 * (DEPTH - 1); v++) smp(8'(v), 8'(v + 1));
        chk("decim_not_done", {31'd0, capture_done}, 32'd0);
        smp(8'(3 * (DEPTH - 1)), 8'(3 * (DEPTH - 1) + 1));
        chk("decim_done", {31'd0, capture_done}, 32'd1);
        rd_chk("live0_a", 5'd8, 16'(3 * (DEPTH - 1)));
        smp(8'd200, 8'd201);
        rd_chk("live0_b", 5'd8, 16'd200);
        rd_chk("live1", 5'd9, 16'd201);
        wr(5'd5, 0);
        for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("decim_%0d", i), 5'd6, 16'(3 * i));
        wr(5'd4, 0);

        // ---- abort, arm+abort, arm during capture
        wr(5'd0, 16'h0001);
        for (int i = 0; i < 5; i++) smp(8'(200 + i), 8'd0);
        wr(5'd0, 16'h0002);
        rd_chk("abort_status", 5'd1, 16'd0);
        chk("abort_done", {31'd0, capture_done}, 32'd0);
        wr(5'd5, 0);
        rd_chk("abort_retain", 5'd6, 16'd200);
        wr(5'd0, 16'h0003);
        rd_chk("arm_abort", 5'd1, 16'd0);
        wr(5'd0, 16'h0001);
        for (int i = 0; i < 3; i++) smp(8'(100 + i), 8'd0);
        wr(5'd0, 16'h0001);
        for (int i = 3; i < DEPTH - 1; i++) smp(8'(100 + i), 8'd0);
        chk("rearm_not_done", {31'd0, capture_done}, 32'd0);
        smp(8'(100 + DEPTH - 1), 8'd0);
        chk("rearm_ignored", {31'd0, capture_done}, 32'd1);
        wr(5'd5, 0);
        rd_chk("rearm_idx0", 5'd6, 16'd100);

        // ---- unmapped / RO access
        rd_chk("rd_addr31", 5'd31, 16'd0);
        wr(5'd6, 16'h1234);
        rd_chk("wr6_ptr", 5'd5, 16'd1);
        rd_chk("wr6_status", 5'd1, 16'd7);
        rd(5'd8, d);
        tick(1);
        chk("rdata_idle", {16'd0, readdata}, 32'd0);

        // ---- gain mapping and reset mid-capture
        wr(5'd16, 2);
        wr(5'd17, 3);
        tick(1);
        chk("gain_code3", {28'd0, gain_sel}, 32'h6);
        wr(5'd2, 16'h0033);
        wr(5'd4, 2);
        wr(5'd0, 16'h0001);
        smp(8'h41, 8'h42);
        smp(8'h43, 8'h44);
        address = 5'd8; read = 1'b1;
        tick(1);
        chk("pre_rst_rdata", {16'd0, readdata}, 32'h43);
        #2 rst = 1'b0;
        #1;
        chk("rst_rdata_async", {16'd0, readdata}, 32'd0);
        chk("rst_gain_async", {28'd0, gain_sel}, 32'h5);
        chk("rst_done_async", {31'd0, capture_done}, 32'd0);
        read = 1'b0;
        #3 rst = 1'b1;
        tick(1);
        rd_chk("post_rst_status", 5'd1, 16'd0);
        rd_chk("post_rst_level", 5'd2, 16'd0);
        rd_chk("post_rst_decim", 5'd4, 16'd0);
        rd_chk("post_rst_live", 5'd8, 16'd0);
        wr(5'd0, 16'h0001);
        for (int i = 0; i < DEPTH; i++) smp(8'(50 + i), 8'd0);
        chk("post_rst_capture", {31'd0, capture_done}, 32'd1);
        wr(5'd5, 0);
        rd_chk("post_rst_idx0", 5'd6, 16'd50);

        // ---- randomized captures against a stream-level model
        for (int it = 0; it < 6; it++) begin
            int dec, ten, fall, lvl, tch, teff, step, start;
            bit have;
            dec  = $urandom_range(0, 4);
            ten  = $urandom_range(0, 1);
            fall = $urandom_range(0, 1);
            lvl  = $urandom_range(16, 240);
            tch  = $urandom_range(0, 3);
            teff = (tch >= NCH) ? 0 : tch;
            step = (dec < 1) ? 1 : dec;
            for (int i = 0; i < NSMP; i++) begin
                s0[i] = $urandom_range(0, 255);
                s1[i] = $urandom_range(0, 255);
            end
            a0.delete(); a1.delete();
            for (int i = 0; i < NSMP; i++) begin
                if (i % step == 0) begin
                    a0.push_back(s0[i]);
                    a1.push_back(s1[i]);
                end
            end
            start = -1;
            if (ten == 0) begin
                start = 0;
            end else begin
                for (int j = 1; j < a0.size() && start < 0; j++) begin
                    int p, s;
                    p = (teff == 0) ? a0[j-1] : a1[j-1];
                    s = (teff == 0) ? a0[j] : a1[j];
                    if (fall == 0 && p < lvl && lvl <= s) start = j;
                    if (fall == 1 && p >= lvl && lvl > s) start = j;
                end
            end
            have = (start >= 0) && (start + DEPTH <= a0.size());

            wr(5'd2, 16'(lvl));
            wr(5'd3, 16'(tch));
            wr(5'd4, 16'(dec));
            wr(5'd0, 16'((fall << 3) | (ten << 2) | 1));
            for (int i = 0; i < NSMP; i++) begin
                smp(8'(s0[i]), 8'(s1[i]));
                if ($urandom_range(0, 3) == 0) tick(1);
            end
            chk($sformatf("rnd%0d_done", it), {31'd0, capture_done}, {31'd0, have});
            rd_chk($sformatf("rnd%0d_live0", it), 5'd8, 16'(s0[NSMP-1]));
            rd_chk($sformatf("rnd%0d_live1", it), 5'd9, 16'(s1[NSMP-1]));
            if (have) begin
                wr(5'd5, 0);
                for (int c = 0; c < NCH; c++) begin
                    wr(5'd7, 16'(c));
                    for (int i = 0; i < DEPTH; i++) begin
                        rd_chk($sformatf("rnd%0d_c%0d_i%0d", it, c, i), 5'd6,
                               16'((c == 0) ? a0[start + i] : a1[start + i]));
                    end
                end
                wr(5'd7, 0);
            end
            wr(5'd0, 16'h0002);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameters SHALL be: NCH, default 2, number of ADC channels (1-8); DW, default 8, sample width (1-16); DEPTH, default 256, capture samples per channel (power of 2, 16-1024).
REQ-002 Ports SHALL be: main_clk  in  1  sole clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 sample_valid  in  1  one-cycle strobe: adc_data holds a new sample set (already synchronous to main_clk).
REQ-005 adc_data  in  NCH*DW  channel k at bits [k*DW +: DW], unsigned.
REQ-006 address  in  5, read  in  1, write  in  1, writedata  in  16, readdata  out  16: Avalon-MM slave.
REQ-007 gain_sel  out  2*NCH  per-channel gain code (0: 2x, 1: 3.5x, 2: 8.5x, 3: treated as 1).
REQ-008 capture_done  out  1  level, high while in DONE.

Function
REQ-009 Register map SHALL be: 0 CTRL (W: bit0 arm, bit1 abort, bit2 trig_en, bit3 trig_falling; R: bits[3:2]); 1 STATUS (RO: [1:0] state, bit2 done); 2 TRIG_LEVEL [DW-1:0]; 3 TRIG_CH; 4 DECIM [15:0]; 5 RD_PTR; 6 RD_DATA (RO); 7 RD_CH; 8..8+NCH-1 LIVE (RO, latest sample per channel); 16..16+NCH-1 GAIN (2 bits).
REQ-010 arm and abort SHALL be write-one pulses, never stored; read of CTRL returns 0 in bits[1:0].
REQ-011 readdata SHALL be registered: valid the cycle after read high; 0 in any cycle following read low; unmapped addresses read 0, unmapped writes ignored; unused upper bits read 0.
REQ-012 Writes to RO registers (1, 6, 8-15) SHALL be ignored.
REQ-013 LIVE[k] SHALL update on every sample_valid, independent of capture state and decimation.
REQ-014 Decimation: a sample is "accepted" on sample_valid when decim_cnt == 0; decim_cnt counts 0..max(DECIM,1)-1 then wraps; DECIM 0 or 1 accepts every sample; decim_cnt clears on arm.
REQ-015 State machine SHALL be IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-016 IDLE/DONE + arm -> ARMED; wr_ptr cleared; first-sample flag set.
REQ-017 ARMED, trig_en=0 -> CAPTURE on next accepted sample, which is stored at index 0.
REQ-018 ARMED, trig_en=1: trigger when accepted sample s on TRIG_CH and previous accepted sample p satisfy p < TRIG_LEVEL <= s (rising) or p >= TRIG_LEVEL > s (falling), unsigned; first accepted sample after arm only loads p, never triggers; triggering sample stored at index 0 -> CAPTURE.
REQ-019 CAPTURE: each accepted sample stores all NCH channels at wr_ptr, wr_ptr++; after the sample at index DEPTH-1 is stored -> DONE; no wrap, no further writes.
REQ-020 abort in any state -> IDLE next cycle; buffer contents retained; abort and arm in same write: abort wins.
REQ-021 arm in ARMED or CAPTURE SHALL be ignored.
REQ-022 TRIG_CH >= NCH SHALL be treated as channel 0.
REQ-023 RD_DATA read returns buffer[RD_CH][RD_PTR] (zero-extended) and increments RD_PTR modulo DEPTH in the same cycle; RD_CH >= NCH reads 0 but still increments.
REQ-024 Write to RD_PTR sets it to writedata mod DEPTH; RD_PTR write and RD_DATA read never coincide (single port).
REQ-025 Buffer reads during CAPTURE SHALL return stored or stale data without disturbing capture.
REQ-026 gain_sel SHALL be registered from GAIN[k], code 3 driven as 1.

Reset
REQ-027 On rst low: state IDLE, wr_ptr, RD_PTR, RD_CH, TRIG_CH, TRIG_LEVEL, DECIM, decim_cnt, CTRL bits 0; gain_sel all 01 (3.5x); LIVE 0; readdata 0; capture_done 0; buffer contents undefined.
REQ-028 Reset mid-capture SHALL abandon capture; first arm after release behaves as REQ-016.

Verification
REQ-029 trig_en=0, DECIM=0, arm, feed ramp 0,1,2... on ch0 -> capture_done after DEPTH-th valid; RD_PTR=0, RD_CH=0, DEPTH RD_DATA reads return 0..DEPTH-1, RD_PTR wraps to 0.
REQ-030 trig_en=1 rising, TRIG_LEVEL=0x80, ch0 sequence 0x10,0x90(first, no trig),0x70,0x80 -> index 0 holds 0x80; falling variant with 0x90,0x70 -> index 0 holds 0x70.
REQ-031 DECIM=3, ramp input -> buffer holds 0,3,6,...; LIVE[0] tracks every sample.
REQ-032 abort mid-CAPTURE -> STATUS state 0 next cycle, capture_done stays 0; arm+abort same write -> IDLE; arm during CAPTURE -> ignored.
REQ-033 rst pulsed low mid-CAPTURE -> all outputs per REQ-027 immediately; gain_sel = 01 per channel; GAIN[1]=3 -> gain_sel[3:2]=01.
REQ-034 Read of address 31 and write to address 6 -> readdata 0, no state change; readdata 0 in cycle after read deasserted.
